// File: rtl/multi_channel_ext_int_ctrl.sv
// rtl/multi_channel_ext_int_ctrl.sv - multi-channel external interrupt detector with per-channel debounce
module multi_channel_ext_int_ctrl #(
    parameter int NUM_CH           = 4,
    parameter int DEBOUNCE_TIMEOUT = 20,
    parameter int PIN_IDLE_STATE   = 1,
    parameter int SYNC_STAGES      = 2,
    localparam int ID_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     int_pin,
    input  logic [NUM_CH-1:0]     enable_mask,
    input  logic [2*NUM_CH-1:0]   sense_ctrl,
    input  logic [NUM_CH-1:0]     debounce_en,
    input  logic                  int_ack,
    output logic                  irq,
    output logic [ID_W-1:0]       irq_id,
    output logic [NUM_CH-1:0]     pending
);

    localparam int CNT_W = $clog2(DEBOUNCE_TIMEOUT + 1);
    localparam logic [NUM_CH-1:0] IDLE_VEC = {NUM_CH{(PIN_IDLE_STATE != 0)}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIMEOUT - 1);

    typedef enum logic {
        ARMED    = 1'b0,
        DEBOUNCE = 1'b1
    } state_t;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] prev_q, prev_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] ack_vec;
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];

    assign s       = sync_q[SYNC_STAGES-1];
    assign pending = pending_q;
    assign irq     = |pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= IDLE_VEC;
            end
            prev_q    <= IDLE_VEC;
            pending_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ARMED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q[0] <= int_pin;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            prev_q    <= prev_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        irq_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                irq_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ack_vec[i] = int_ack && pending_q[i] && (irq_id == ID_W'(i));
        end
    end

    always_comb begin
        ev = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (sense_ctrl[2*i +: 2])
                2'b00:   ev[i] = ~prev_q[i] & s[i];
                2'b01:   ev[i] = prev_q[i] & ~s[i];
                2'b10:   ev[i] = prev_q[i] ^ s[i];
                default: ev[i] = ~s[i];
            endcase
        end
    end

    // A new detection is OR-ed in after the ack clear so that set wins over ack.
    always_comb begin
        prev_d    = s;
        pending_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!enable_mask[i]) begin
                state_d[i] = ARMED;
                cnt_d[i]   = '0;
            end else begin
                pending_d[i] = pending_q[i] & ~ack_vec[i];
                case (state_q[i])
                    ARMED: begin
                        if (ev[i]) begin
                            pending_d[i] = 1'b1;
                            if (debounce_en[i] && (sense_ctrl[2*i +: 2] != 2'b11)) begin
                                state_d[i] = DEBOUNCE;
                                cnt_d[i]   = '0;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        // prev is frozen while blind and resynced to s on exit.
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ARMED;
                            cnt_d[i]   = '0;
                        end else begin
                            prev_d[i] = prev_q[i];
                            cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ARMED;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/multi_channel_ext_int_ctrl.md
MULTI_CHANNEL_EXT_INT_CTRL -- requirements
Module: multi_channel_ext_int_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- NUM_CH, default 4: number of external interrupt channels (1..32).
- DEBOUNCE_TIMEOUT, default 20: clock cycles a channel ignores events after a debounced detection.
- PIN_IDLE_STATE, default 1: pin level assumed at reset.
- SYNC_STAGES, default 2: input synchroniser depth (>=2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- int_pin  in  NUM_CH  asynchronous external pins.
- enable_mask  in  NUM_CH  per-channel enable.
- sense_ctrl  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 rise, 01 fall, 10 change, 11 low level.
- debounce_en  in  NUM_CH  per-channel debounce enable.
- int_ack  in  1  one-cycle acknowledge of the channel on irq_id.
- irq  out  1  OR of all pending bits.
- irq_id  out  max(1,$clog2(NUM_CH))  lowest-index pending channel.
- pending  out  NUM_CH  registered pending flags.

Function
REQ-003 Each int_pin bit SHALL pass through a SYNC_STAGES flip-flop synchroniser; all detection uses only the last stage (s).
REQ-004 Each channel SHALL hold a prev register; rise = ~prev & s, fall = prev & ~s, change = prev ^ s. prev updates to s every cycle except in DEBOUNCE.
REQ-005 Each channel SHALL run a two-state FSM, ARMED and DEBOUNCE, with a $clog2(DEBOUNCE_TIMEOUT+1)-bit counter.
REQ-006 In ARMED, an event matching sense_ctrl SHALL set pending[i] on the same clock edge; if debounce_en[i]=1 the FSM SHALL enter DEBOUNCE with counter=0.
REQ-007 In DEBOUNCE, the counter SHALL increment each cycle and events SHALL be ignored; when counter reaches DEBOUNCE_TIMEOUT-1 the FSM SHALL return to ARMED and load prev with current s, so no spurious edge is seen on exit.
REQ-008 Mode 11 (low level) SHALL set pending[i] every cycle s=0, SHALL ignore debounce_en, and SHALL never enter DEBOUNCE.
REQ-009 Latency: a pin transition first sampled at edge k SHALL set pending at edge k+SYNC_STAGES; irq SHALL follow pending combinationally.
REQ-010 irq_id SHALL be the lowest index with pending=1, and 0 when none pending.
REQ-011 int_ack=1 SHALL clear pending[irq_id] at the next edge; int_ack with irq=0 SHALL have no effect.
REQ-012 Simultaneous ack and new set on the same channel: set SHALL win (pending stays 1).
REQ-013 enable_mask[i]=0 SHALL force pending[i]=0 and FSM to ARMED with counter=0, while prev keeps tracking s; re-enabling SHALL NOT report edges that occurred while disabled.
REQ-014 sense_ctrl or debounce_en changes SHALL take effect on the next detection evaluation and SHALL NOT abort a DEBOUNCE in progress.
REQ-015 Channels SHALL be fully independent; simultaneous events on several channels SHALL each set their own pending bit in the same cycle.

Reset
REQ-016 While rst=1 at a clock edge: synchroniser stages and prev SHALL load PIN_IDLE_STATE, pending=0, irq=0, irq_id=0, all FSMs ARMED, counters 0; reset SHALL override any in-progress debounce or ack.
REQ-017 The first cycle after rst deasserts SHALL generate no event if pins equal PIN_IDLE_STATE.

Verification
REQ-018 Ch0 mode 00, no debounce, pin 0->1 sampled at edge k -> pending=0001, irq=1, irq_id=0 at edge k+2; int_ack one cycle -> pending=0000.
REQ-019 Ch1 mode 01, debounce_en=1, DEBOUNCE_TIMEOUT=20, pin falls then bounces 5 times within 15 cycles -> exactly one pending set, no re-set during bounce, after ack pending stays 0.
REQ-020 Ch2 mode 10, pin rises then falls 30 cycles later, no debounce -> two pending sets, each cleared by its own ack.
REQ-021 Ch1 and ch3 fire on the same edge -> pending=1010, irq_id=1; ack -> pending=1000, irq_id=3; ack -> pending=0000, irq=0.
REQ-022 Ch0 mode 11 held low while acking every cycle -> pending re-asserts each cycle (set wins); enable_mask[0]=0 -> pending[0]=0 next edge.
REQ-023 rst asserted mid-DEBOUNCE with pending=0100 -> next edge pending=0000, irq=0; after release, pin at idle level generates no event.
